truth_table_checker: RTL and testbench

// - Synthesizable exhaustive stimulus generator and response checker for a 3-input, 2-output combinational DUT.
// - Drives a,b,c through all 8 combinations in order 000..111, with a the MSB.
// - Waits a settle interval per case, then samples x,y and compares them against parameterized expected truth tables.
// - Reports a mismatch count and a pass flag; it is the on-chip checking end of the a/b/c -> x/y test interface.

---
 rtl/truth_table_checker.sv | 105 ++++++++++
 tb/tb_truth_table_checker.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/truth_table_checker.sv
// Exhaustive stimulus generator and response checker for a 3-input, 2-output
// combinational DUT. Sweeps {a,b,c} through 000..111 (a is the MSB), holds each
// vector for SETTLE_CYCLES cycles, then samples x/y for one cycle and compares
// them against the expected truth tables.
//
// Ports:
//   clk             - system clock, rising edge
//   reset           - asynchronous active-high reset
//   start           - begin a sweep; honoured only when idle or done
//   x, y            - DUT responses (assumed synchronous to clk)
//   a, b, c         - DUT stimulus, {a,b,c} == case_idx
//   case_idx        - current case number
//   busy            - sweep in progress
//   done            - sweep finished; sticky until next start or reset
//   pass            - valid with done; high when no case mismatched
//   fail_count      - number of mismatching cases (0..8)
//   first_fail_case - case_idx of the first mismatch, 0 if none
module truth_table_checker #(
  parameter int unsigned SETTLE_CYCLES = 20,
  parameter logic [7:0]  EXPECTED_X    = 8'h00,
  parameter logic [7:0]  EXPECTED_Y    = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       x,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic [2:0] case_idx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_count,
  output logic [2:0] first_fail_case
);

  typedef enum logic [1:0] {StIdle, StDrive, StCheck, StDone} state_t;

  localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [7:0] settle_cnt;
  logic       mismatch;

  // case_idx is a register, so the stimulus only changes on a clock edge.
  assign {a, b, c} = case_idx;

  assign mismatch = (x != EXPECTED_X[case_idx]) || (y != EXPECTED_Y[case_idx]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= StIdle;
      settle_cnt      <= 8'd0;
      case_idx        <= 3'd0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      fail_count      <= 4'd0;
      first_fail_case <= 3'd0;
    end else begin
      unique case (state)
        StIdle, StDone: begin
          if (start) begin
            state           <= StDrive;
            settle_cnt      <= 8'd0;
            case_idx        <= 3'd0;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            fail_count      <= 4'd0;
            first_fail_case <= 3'd0;
          end
        end
        StDrive: begin
          if (settle_cnt == SettleLast) begin
            settle_cnt <= 8'd0;
            state      <= StCheck;
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end
        StCheck: begin
          if (mismatch) begin
            fail_count <= fail_count + 4'd1;
            if (fail_count == 4'd0) first_fail_case <= case_idx;
          end
          if (case_idx == 3'd7) begin
            state <= StDone;
            busy  <= 1'b0;
            done  <= 1'b1;
            // Include this cycle's result, which fail_count does not yet hold.
            pass  <= (fail_count == 4'd0) && !mismatch;
          end else begin
            case_idx <= case_idx + 3'd1;
            state    <= StDrive;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_checker.sv
module tb_truth_table_checker;

  localparam int Settle0 = 20;
  localparam int Settle1 = 1;

  typedef struct {
    int fc;
    int ff;
    int ps;
    int lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic       x0, y0, x1, y1;
  logic       a0, b0, c0, busy0, done0, pass0;
  logic       a1, b1, c1, busy1, done1, pass1;
  logic [2:0] ci0, ff0, ci1, ff1;
  logic [3:0] fc0, fc1;
  int         mode = 0;
  logic       y1_val = 1'b0;
  int         n_cmp = 0;
  int         n_err = 0;
  exp_t       sb[$];

  always #5 clk = ~clk;

  // Behavioural DUT models driven by the checker's stimulus.
  assign x0 = (mode == 1) ? 1'b1 : (mode == 2) ? (a0 & ~b0 & c0) : 1'b0;
  assign y0 = 1'b0;
  assign x1 = 1'b0;
  assign y1 = y1_val;

  truth_table_checker #(.SETTLE_CYCLES(Settle0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .x(x0), .y(y0),
    .a(a0), .b(b0), .c(c0), .case_idx(ci0), .busy(busy0), .done(done0),
    .pass(pass0), .fail_count(fc0), .first_fail_case(ff0)
  );

  truth_table_checker #(.SETTLE_CYCLES(Settle1), .EXPECTED_X(8'h00), .EXPECTED_Y(8'hFF)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .x(x1), .y(y1),
    .a(a1), .b(b1), .c(c1), .case_idx(ci1), .busy(busy1), .done(done1),
    .pass(pass1), .fail_count(fc1), .first_fail_case(ff1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse start on one checker, wait (bounded) for done, then pop the
  // scoreboard entry and compare. With mon set, also watch dut0's stimulus
  // sequence and busy, and fire stray start pulses mid-sweep.
  task automatic run_sweep(input int which, input exp_t e, input bit mon);
    exp_t       want;
    int         k, run, seq_err, busy_err, settle;
    logic [2:0] prev, cur;
    bit         d;
    settle = which ? Settle1 : Settle0;
    sb.push_back(e);
    @(negedge clk);
    if (which == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    check("done_cleared_on_start", which ? done1 : done0, 0);
    check("fc_cleared_on_start", which ? fc1 : fc0, 0);
    check("busy_on_start", which ? busy1 : busy0, 1);
    k = 0;
    prev = {a0, b0, c0};
    run = 1;
    seq_err = 0;
    busy_err = 0;
    if (mon) check("abc_first_case", prev, 0);
    d = 1'b0;
    while (!d && k < 2000) begin
      if (mon && (k == 50 || k == 120)) start0 = 1'b1;
      @(posedge clk);
      #1;
      start0 = 1'b0;
      k++;
      d = which ? done1 : done0;
      if (mon) begin
        cur = {a0, b0, c0};
        if (!d && !busy0) busy_err++;
        if (cur != prev) begin
          if (run != settle + 1 || cur != prev + 3'd1) seq_err++;
          prev = cur;
          run = 1;
        end else begin
          run++;
        end
      end
    end
    want = sb.pop_front();
    check("done_latency", k, want.lat);
    check("fail_count", which ? fc1 : fc0, want.fc);
    check("first_fail_case", which ? ff1 : ff0, want.ff);
    check("pass", which ? pass1 : pass0, want.ps);
    check("busy_low_at_done", which ? busy1 : busy0, 0);
    if (mon) begin
      check("abc_sequence_errors", seq_err, 0);
      check("busy_drop_errors", busy_err, 0);
      check("abc_final", prev, 7);
    end
  endtask

  initial begin
    int k;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_abc", {a0, b0, c0}, 0);
    check("rst_case_idx", ci0, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_pass", pass0, 0);
    check("rst_fail_count", fc0, 0);
    check("rst_first_fail", ff0, 0);
    @(negedge clk);
    reset = 1'b0;

    // T1 + T4: all-zero DUT matches defaults; monitor stimulus, stray starts
    mode = 0;
    run_sweep(0, '{fc: 0, ff: 0, ps: 1, lat: 168}, 1'b1);
    check("done_sticky", done0, 1);

    // T2: x stuck at 1 -> every case fails
    mode = 1;
    run_sweep(0, '{fc: 8, ff: 0, ps: 0, lat: 168}, 1'b0);

    // T3: x = a&~b&c -> only case 5 fails
    mode = 2;
    run_sweep(0, '{fc: 1, ff: 5, ps: 0, lat: 168}, 1'b0);

    // T5: reset in DRIVE of case 3
    mode = 1;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    k = 0;
    while (!(ci0 == 3'd3 && busy0) && k < 500) begin
      @(posedge clk);
      #1;
      k++;
    end
    repeat (4) @(posedge clk);
    #1;
    check("mid_case_idx", ci0, 3);
    check("mid_fc_before_rst", fc0, 3);
    reset = 1'b1;
    #1;
    check("midrst_abc", {a0, b0, c0}, 0);
    check("midrst_busy", busy0, 0);
    check("midrst_done", done0, 0);
    check("midrst_fail_count", fc0, 0);
    @(negedge clk);
    reset = 1'b0;
    mode = 2;
    run_sweep(0, '{fc: 1, ff: 5, ps: 0, lat: 168}, 1'b1);

    // T6: SETTLE_CYCLES=1, EXPECTED_Y=FF; failing run, then passing run from DONE
    y1_val = 1'b0;
    run_sweep(1, '{fc: 8, ff: 0, ps: 0, lat: 16}, 1'b0);
    y1_val = 1'b1;
    run_sweep(1, '{fc: 0, ff: 0, ps: 1, lat: 16}, 1'b0);
    check("t6_abc_hold", {a1, b1, c1}, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
